trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Machine-mode trap and interrupt controller for the pipelined RV32 core.
- Synchronises the external `interrupter` line and holds it as a pending interrupt.
- Arbitrates between MEM-stage exceptions (ecall, illegal instruction), the pending interrupt, and mret.
- Owns the M-mode CSRs (mstatus, mie, mip, mtvec, mepc, mcause), and sequences pipeline flush and PC redirect on trap entry and exit.

Parameters:
- MTVEC_RESET, 32'h0000_0100, reset value of mtvec; bits [1:0] are ignored.
- SYNC_STAGES, 2, number of flip-flops in the interrupter synchroniser; legal values are 2 or 3.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- interrupter  in  1  raw external interrupt, asynchronous to clk.
- mem_valid  in  1  the MEM stage holds a real instruction, not a bubble.
- pc_mem  in  32  PC of the MEM-stage instruction.
- ecall_mem  in  1  MEM-stage instruction is ecall.
- illegal_mem  in  1  MEM-stage instruction is illegal.
- mret_mem  in  1  MEM-stage instruction is mret.
- csr_we  in  1  CSR write strobe.
- csr_addr  in  12  CSR address, shared by reads and writes.
- csr_wdata  in  32  CSR write data.
- csr_rdata  out  32  combinational CSR read data.
- flush  out  1  squash IF/ID/EX/MEM this cycle.
- redirect  out  1  load redirect_pc into the PC this cycle.
- redirect_pc  out  32  redirect target.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Synchroniser flops and the edge register clear to 0; pending clears to 0.
  - mstatus, mie, mepc and mcause clear to 0; mtvec loads {MTVEC_RESET[31:2],2'b00}.
  - flush, redirect and redirect_pc are 0.
  - Reset mid-trap abandons the sequence; flush and redirect drop immediately.
- CSR map:
  - 0x300 mstatus: only MIE (bit 3) and MPIE (bit 7) are stored; other bits read 0.
  - 0x304 mie: only MEIE (bit 11) is stored.
  - 0x344 mip: MEIP (bit 11) reads as pending; writes are ignored.
  - 0x305 mtvec: bits [1:0] are forced to 0.
  - 0x341 mepc: bits [1:0] are forced to 0.
  - 0x342 mcause: all 32 bits are writable.
  - Any other address reads 0, and writes to it are ignored.
  - Writes take effect at the clock edge.
- Interrupt capture:
  - interrupter passes through SYNC_STAGES flops.
  - Rising-edge detect compares the synchroniser output with its delayed copy.
  - An edge sets pending; pending is edge-triggered and does not count, so extra edges while pending stay a single pending.
  - Holding interrupter high produces exactly one pending.
  - pending clears only on interrupt trap entry, or on reset.
  - With SYNC_STAGES=2, interrupter sampled high at edge E0 makes pending=1 after edge E2.
- Trap decision, evaluated in IDLE with mem_valid=1, in priority order:
  1. illegal_mem → exception, cause 2.
  2. ecall_mem → exception, cause 11.
  3. pending & MIE & MEIE → interrupt, cause 32'h8000_000B.
  4. mret_mem → return.
  - If none applies, stay in IDLE.
  - With mem_valid=0, nothing is taken.
  - An exception taken while an interrupt is pending leaves pending set.
- Trap entry (IDLE→TRAP, at the clock edge):
  - mepc←pc_mem and mcause←cause.
  - MPIE←MIE, then MIE←0.
  - pending←0, for interrupts only.
  - These updates override a same-cycle csr_we to the same CSR.
  - The MEM-stage instruction does not commit.
- TRAP state (exactly 1 cycle):
  - flush=1, redirect=1, redirect_pc=mtvec. Next state is IDLE.
- Return (IDLE→MRET, at the clock edge):
  - MIE←MPIE and MPIE←1.
- MRET state (exactly 1 cycle):
  - flush=1, redirect=1, redirect_pc=mepc. Next state is IDLE.
- Events arriving in TRAP or MRET are ignored, because those instructions are being flushed. Pending is retained and re-evaluated in IDLE.
- flush and redirect are registered state decodes: they are high only in TRAP or MRET and low otherwise.
- Latency from decision cycle to redirect is 1 cycle. Back-to-back traps are at least 2 cycles apart.

Test Plan:
- Reset check: pulse rst=0 mid-simulation → flush=0, redirect=0; csr_rdata at 0x305 = 32'h100, at 0x300 = 0, at 0x344 = 0.
- Interrupt entry:
  - Stimulus: write mstatus=0x8, mie=0x800, mtvec=0x200; hold mem_valid=1, pc_mem=0x40; drive interrupter high for 5 cycles.
  - Required: exactly one 1-cycle flush/redirect pulse with redirect_pc=0x200.
  - Then mepc=0x40, mcause=0x8000000B, mstatus=0x80, mip=0.
- Return: following the interrupt-entry test, assert mret_mem with mem_valid=1 → next cycle redirect with redirect_pc=0x40; mstatus reads 0x88 afterwards.
- Masked interrupt:
  - Stimulus: mstatus=0, then an interrupter pulse.
  - Required: mip reads 0x800 and no redirect for 20 cycles.
  - Then write mstatus=0x8 → redirect within 2 cycles and mcause=0x8000000B.
- Priority:
  - Stimulus: pending interrupt, enables set, ecall_mem=1, pc_mem=0x80.
  - Required: mcause=11, mepc=0x80, mip still 0x800.
  - After mret_mem, the interrupt is taken.
- Async reset during TRAP: drop rst to 0 mid-cycle while flush=1 → flush and redirect fall without waiting for a clock edge; mepc=0.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap and interrupt controller for the pipelined RV32 core.
// Synchronises the external interrupter line into a sticky pending bit, picks
// between MEM-stage exceptions, the pending interrupt and mret, owns the M-mode
// CSRs, and produces a one-cycle flush/redirect pulse on trap entry and exit.
//
// Ports:
//   clk, rst            core clock, asynchronous active-low reset
//   interrupter         raw external interrupt (asynchronous to clk)
//   mem_valid, pc_mem   MEM-stage instruction valid and its PC
//   ecall_mem, illegal_mem, mret_mem   MEM-stage instruction class
//   csr_we, csr_addr, csr_wdata        CSR write port (address shared with read)
//   csr_rdata           combinational CSR read data
//   flush, redirect     squash IF..MEM / load redirect_pc, high in TRAP or MRET
//   redirect_pc         mtvec in TRAP, mepc in MRET, 0 otherwise
module trap_ctrl #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        interrupter,
    input  logic        mem_valid,
    input  logic [31:0] pc_mem,
    input  logic        ecall_mem,
    input  logic        illegal_mem,
    input  logic        mret_mem,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] CAUSE_EXT_IRQ = 32'h8000_000B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRAP = 2'd1,
        ST_MRET = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_nx_s;
    logic [SYNC_STAGES-1:0]   sync_r;
    logic                     edge_r;
    logic                     rise_s;
    logic                     pending_r;
    logic                     mstatus_mie_r;
    logic                     mstatus_mpie_r;
    logic                     mie_meie_r;
    logic [29:0]              mtvec_r;
    logic [29:0]              mepc_r;
    logic [31:0]              mcause_r;
    logic                     take_exc_s;
    logic                     take_irq_s;
    logic                     take_ret_s;
    logic                     take_trap_s;
    logic [31:0]              cause_s;

    // Interrupter synchroniser chain plus the delayed copy used for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= '0;
            edge_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], interrupter};
            edge_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise_s = sync_r[SYNC_STAGES-1] & ~edge_r;

    // Sticky pending bit: taking the interrupt wins over a coincident edge,
    // which would otherwise merge into the interrupt being taken anyway.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r <= 1'b0;
        end else if (take_irq_s) begin
            pending_r <= 1'b0;
        end else if (rise_s) begin
            pending_r <= 1'b1;
        end
    end

    // Trap decision in priority order; only IDLE looks at the MEM stage,
    // since TRAP and MRET cycles see instructions that are being flushed.
    always_comb begin
        take_exc_s = 1'b0;
        take_irq_s = 1'b0;
        take_ret_s = 1'b0;
        cause_s    = 32'h0000_0000;
        state_nx_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (!mem_valid) begin
                    state_nx_s = ST_IDLE;
                end else if (illegal_mem) begin
                    take_exc_s = 1'b1;
                    cause_s    = CAUSE_ILLEGAL;
                    state_nx_s = ST_TRAP;
                end else if (ecall_mem) begin
                    take_exc_s = 1'b1;
                    cause_s    = CAUSE_ECALL;
                    state_nx_s = ST_TRAP;
                end else if (pending_r && mstatus_mie_r && mie_meie_r) begin
                    take_irq_s = 1'b1;
                    cause_s    = CAUSE_EXT_IRQ;
                    state_nx_s = ST_TRAP;
                end else if (mret_mem) begin
                    take_ret_s = 1'b1;
                    state_nx_s = ST_MRET;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_TRAP: state_nx_s = ST_IDLE;
            ST_MRET: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    assign take_trap_s = take_exc_s | take_irq_s;

    // State register; an async reset mid-sequence drops flush/redirect at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // mstatus MIE/MPIE: trap entry and return take precedence over CSR writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
        end else if (take_trap_s) begin
            mstatus_mpie_r <= mstatus_mie_r;
            mstatus_mie_r  <= 1'b0;
        end else if (take_ret_s) begin
            mstatus_mie_r  <= mstatus_mpie_r;
            mstatus_mpie_r <= 1'b1;
        end else if (csr_we && (csr_addr == ADDR_MSTATUS)) begin
            mstatus_mie_r  <= csr_wdata[3];
            mstatus_mpie_r <= csr_wdata[7];
        end
    end

    // mepc and mcause: captured on trap entry, otherwise software writable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mepc_r   <= 30'd0;
            mcause_r <= 32'h0000_0000;
        end else if (take_trap_s) begin
            mepc_r   <= pc_mem[31:2];
            mcause_r <= cause_s;
        end else begin
            if (csr_we && (csr_addr == ADDR_MEPC)) begin
                mepc_r <= csr_wdata[31:2];
            end
            if (csr_we && (csr_addr == ADDR_MCAUSE)) begin
                mcause_r <= csr_wdata;
            end
        end
    end

    // mie.MEIE and mtvec: plain software-written registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mie_meie_r <= 1'b0;
            mtvec_r    <= MTVEC_RESET[31:2];
        end else begin
            if (csr_we && (csr_addr == ADDR_MIE)) begin
                mie_meie_r <= csr_wdata[11];
            end
            if (csr_we && (csr_addr == ADDR_MTVEC)) begin
                mtvec_r <= csr_wdata[31:2];
            end
        end
    end

    // Combinational CSR read mux; unstored bits and unknown addresses read 0.
    always_comb begin
        csr_rdata = 32'h0000_0000;
        case (csr_addr)
            ADDR_MSTATUS: csr_rdata = {24'd0, mstatus_mpie_r, 3'd0, mstatus_mie_r, 3'd0};
            ADDR_MIE:     csr_rdata = {20'd0, mie_meie_r, 11'd0};
            ADDR_MIP:     csr_rdata = {20'd0, pending_r, 11'd0};
            ADDR_MTVEC:   csr_rdata = {mtvec_r, 2'b00};
            ADDR_MEPC:    csr_rdata = {mepc_r, 2'b00};
            ADDR_MCAUSE:  csr_rdata = mcause_r;
            default:      csr_rdata = 32'h0000_0000;
        endcase
    end

    // Outputs are pure decodes of the state register.
    always_comb begin
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        case (state_r)
            ST_TRAP: begin
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = {mtvec_r, 2'b00};
            end
            ST_MRET: begin
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = {mepc_r, 2'b00};
            end
            default: begin
                flush       = 1'b0;
                redirect    = 1'b0;
                redirect_pc = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the trap rules.
module tb_trap_ctrl;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        interrupter;
    logic        mem_valid;
    logic [31:0] pc_mem;
    logic        ecall_mem;
    logic        illegal_mem;
    logic        mret_mem;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_pend, m_mie, m_mpie, m_meie;
    logic [31:0] m_mtvec, m_mepc, m_mcause;
    int          m_phase;   // 0 none, 1 trap redirect, 2 return redirect
    bit          samp[$];   // interrupter samples, newest first

    trap_ctrl #(.MTVEC_RESET(32'h0000_0100), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .interrupter(interrupter), .mem_valid(mem_valid),
        .pc_mem(pc_mem), .ecall_mem(ecall_mem), .illegal_mem(illegal_mem),
        .mret_mem(mret_mem), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        logic [31:0] v;
        v = 32'h0;
        case (a)
            12'h300: v = (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304: v = 32'(m_meie) << 11;
            12'h344: v = 32'(m_pend) << 11;
            12'h305: v = m_mtvec;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    task automatic m_reset();
        m_pend = 1'b0; m_mie = 1'b0; m_mpie = 1'b0; m_meie = 1'b0;
        m_mtvec = 32'h100; m_mepc = 32'h0; m_mcause = 32'h0; m_phase = 0;
        samp = '{1'b0, 1'b0, 1'b0, 1'b0};
    endtask

    // Apply one clock edge's worth of the trap rules to the model.
    task automatic m_edge();
        bit rise, trap, irq, ret, o_mie, o_mpie;
        logic [31:0] cause;
        rise = samp[S-1] && !samp[S];
        trap = 1'b0; irq = 1'b0; ret = 1'b0; cause = 32'h0;
        o_mie = m_mie; o_mpie = m_mpie;
        if (m_phase == 0 && mem_valid) begin
            if (illegal_mem)                       begin trap = 1'b1; cause = 32'd2; end
            else if (ecall_mem)                    begin trap = 1'b1; cause = 32'd11; end
            else if (m_pend && m_mie && m_meie)    begin trap = 1'b1; irq = 1'b1; cause = 32'h8000_000B; end
            else if (mret_mem)                     ret = 1'b1;
        end
        if (csr_we) begin
            case (csr_addr)
                12'h300: begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
                12'h304: m_meie = csr_wdata[11];
                12'h305: m_mtvec = {csr_wdata[31:2], 2'b00};
                12'h341: m_mepc = {csr_wdata[31:2], 2'b00};
                12'h342: m_mcause = csr_wdata;
                default: ;
            endcase
        end
        if (trap) begin
            m_mepc = {pc_mem[31:2], 2'b00};
            m_mcause = cause;
            m_mpie = o_mie;
            m_mie = 1'b0;
        end
        if (ret) begin
            m_mie = o_mpie;
            m_mpie = 1'b1;
        end
        if (irq)       m_pend = 1'b0;
        else if (rise) m_pend = 1'b1;
        m_phase = trap ? 1 : (ret ? 2 : 0);
        samp.push_front(interrupter);
        void'(samp.pop_back());
    endtask

    task automatic step();
        logic [31:0] exp_pc;
        m_edge();
        @(posedge clk);
        #1;
        exp_pc = (m_phase == 1) ? m_mtvec : ((m_phase == 2) ? m_mepc : 32'h0);
        chk("flush", 32'(flush), 32'(m_phase != 0));
        chk("redirect", 32'(redirect), 32'(m_phase != 0));
        chk("redirect_pc", redirect_pc, exp_pc);
    endtask

    task automatic rdc(input logic [11:0] a, input string tag, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
        chk({tag, "_model"}, csr_rdata, m_read(a));
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        step();
        csr_we = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [11:0] addrs [7];
        addrs = '{12'h300, 12'h304, 12'h344, 12'h305, 12'h341, 12'h342, 12'h7C0};

        rst = 1'b0; interrupter = 1'b0; mem_valid = 1'b0; pc_mem = 32'h0;
        ecall_mem = 1'b0; illegal_mem = 1'b0; mret_mem = 1'b0;
        csr_we = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
        m_reset();
        #12;
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_redirect", 32'(redirect), 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        rdc(12'h305, "rst_mtvec", 32'h100);
        rdc(12'h300, "rst_mstatus", 32'h0);
        rdc(12'h344, "rst_mip", 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Interrupt entry
        wr(12'h300, 32'h8);
        wr(12'h304, 32'h800);
        wr(12'h305, 32'h200);
        mem_valid = 1'b1; pc_mem = 32'h40;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            interrupter = (i < 5);
            step();
            if (redirect) begin
                cnt++;
                chk("irq_target", redirect_pc, 32'h200);
            end
        end
        chk("irq_pulses", 32'(cnt), 32'd1);
        rdc(12'h341, "irq_mepc", 32'h40);
        rdc(12'h342, "irq_mcause", 32'h8000_000B);
        rdc(12'h300, "irq_mstatus", 32'h80);
        rdc(12'h344, "irq_mip", 32'h0);

        // Return
        mret_mem = 1'b1;
        step();
        mret_mem = 1'b0;
        chk("ret_redirect", 32'(redirect), 32'h1);
        chk("ret_pc", redirect_pc, 32'h40);
        step();
        rdc(12'h300, "ret_mstatus", 32'h88);

        // Masked interrupt
        wr(12'h300, 32'h0);
        interrupter = 1'b1;
        step();
        interrupter = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (redirect) cnt++;
        end
        chk("masked_no_redirect", 32'(cnt), 32'd0);
        rdc(12'h344, "masked_mip", 32'h800);
        wr(12'h300, 32'h8);
        cnt = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (redirect) cnt++;
        end
        chk("unmask_redirect", 32'(cnt), 32'd1);
        rdc(12'h342, "unmask_mcause", 32'h8000_000B);

        // Priority: ecall beats a pending, enabled interrupt
        mem_valid = 1'b0;
        interrupter = 1'b1;
        step();
        interrupter = 1'b0;
        for (int i = 0; i < 3; i++) step();
        wr(12'h300, 32'h8);
        mem_valid = 1'b1; ecall_mem = 1'b1; pc_mem = 32'h80;
        step();
        chk("prio_redirect", 32'(redirect), 32'h1);
        ecall_mem = 1'b0; mem_valid = 1'b0;
        step();
        rdc(12'h342, "prio_mcause", 32'd11);
        rdc(12'h341, "prio_mepc", 32'h80);
        rdc(12'h344, "prio_mip", 32'h800);
        mem_valid = 1'b1; mret_mem = 1'b1;
        step();
        chk("prio_ret_pc", redirect_pc, 32'h80);
        mret_mem = 1'b0; pc_mem = 32'h90;
        step();
        step();
        chk("prio_irq_redirect", 32'(redirect), 32'h1);
        rdc(12'h342, "prio_irq_mcause", 32'h8000_000B);
        rdc(12'h341, "prio_irq_mepc", 32'h90);

        // Async reset during TRAP
        step();
        ecall_mem = 1'b1; pc_mem = 32'hC0;
        step();
        ecall_mem = 1'b0;
        chk("pre_rst_flush", 32'(flush), 32'h1);
        #2;
        rst = 1'b0;
        m_reset();
        #1;
        chk("async_flush", 32'(flush), 32'h0);
        chk("async_redirect", 32'(redirect), 32'h0);
        rdc(12'h341, "async_mepc", 32'h0);
        rdc(12'h305, "async_mtvec", 32'h100);
        mem_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) interrupter = ~interrupter;
            mem_valid   = ($urandom_range(0, 3) != 0);
            pc_mem      = $urandom;
            illegal_mem = ($urandom_range(0, 15) == 0);
            ecall_mem   = ($urandom_range(0, 15) == 0);
            mret_mem    = ($urandom_range(0, 9) == 0);
            csr_we      = ($urandom_range(0, 3) == 0);
            csr_addr    = addrs[$urandom_range(0, 6)];
            csr_wdata   = $urandom;
            if (csr_addr == 12'h300 && $urandom_range(0, 1) == 1) csr_wdata = 32'h8;
            step();
            csr_we = 1'b0;
            csr_addr = addrs[$urandom_range(0, 6)];
            #1;
            chk("rand_rdata", csr_rdata, m_read(csr_addr));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
